// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout, zero
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial DIFF = A - B, LSB first, one difference/borrow cell per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is high
// SHIFT | one bit per cycle through the difference/borrow cell
// DONE  | one-cycle done pulse, results already registered
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q, zero_q, done_q, busy_q;
  logic             x, y, d, borrow_nxt, last;
  logic [WIDTH-1:0] res_nxt;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  always_comb begin
    x          = sa_q[0];
    y          = sb_q[0];
    d          = x ^ y ^ borrow_q;
    borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);
    res_nxt    = {d, res_q[WIDTH-1:1]};
    last       = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == SHIFT) && last;
      busy_q <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sa_q     <= bus.a;
            sb_q     <= bus.b;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
          end
        end
        SHIFT: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          res_q    <= res_nxt;
          borrow_q <= borrow_nxt;
          cnt_q    <= cnt_q + 1'b1;
          // Visible results change only here, so they hold through the next op.
          if (last) begin
            diff_q <= res_nxt;
            bout_q <= borrow_nxt;
            zero_q <= (res_nxt == '0);
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (x ^ y) & (x ^ d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule
